qmult_seq: RTL and testbench

//  Sequential shift-add multiplier for 32-bit sign-magnitude fixed-point data.

---
 rtl/qmult_seq.sv | 115 +++++++++++
 tb/tb_qmult_seq.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/qmult_seq.sv
// Sign-magnitude fixed-point shift-add multiplier; accept-to-out_valid = DATA_W-1 cycles.
// Single op in flight: in_ready only in IDLE; prod/ovf held in DONE until out_ready.
module qmult_seq #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] prod,
    output logic              ovf
);

    localparam int MAG_W = DATA_W - 1;
    localparam int ACC_W = 2 * MAG_W;
    localparam int CNT_W = $clog2(MAG_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [MAG_W-1:0]   ma_q, ma_d;
    logic [MAG_W-1:0]   mb_q, mb_d;
    logic               sign_q, sign_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  prod_q, prod_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W-1:0]   addend;
    logic [ACC_W-1:0]   acc_sum;
    logic [MAG_W-1:0]   mag;
    logic               ovf_w;

    assign addend  = mb_q[cnt_q] ? (ACC_W'(ma_q) << cnt_q) : '0;
    assign acc_sum = acc_q + addend;
    assign mag     = acc_sum[MAG_W-1+FRAC_W:FRAC_W];
    assign ovf_w   = |acc_sum[ACC_W-1:MAG_W+FRAC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ma_q    <= '0;
            mb_q    <= '0;
            sign_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            sign_q  <= sign_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        sign_d  = sign_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ma_d    = a[MAG_W-1:0];
                    mb_d    = b[MAG_W-1:0];
                    sign_d  = a[DATA_W-1] ^ b[DATA_W-1];
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CNT_W'(1);
                // Final partial product is folded straight into the result registers.
                if (cnt_q == CNT_W'(MAG_W - 1)) begin
                    prod_d  = {sign_q & (|mag), mag};
                    ovf_d   = ovf_w;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign prod      = prod_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_qmult_seq.sv
// Bench for qmult_seq: directed and random operands against an arithmetic reference.
module tb_qmult_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] prod;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    qmult_seq #(.DATA_W(32), .FRAC_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: full-width integer product of the magnitudes, then rescale by 2^-16.
    task automatic model(input logic [31:0] ai, input logic [31:0] bi,
                         output logic [31:0] ep, output logic eo);
        logic [63:0] full;
        logic [30:0] m;
        full = 64'(ai[30:0]) * 64'(bi[30:0]);
        m    = full[46:16];
        eo   = (full[63:47] != 17'd0);
        ep   = {(ai[31] ^ bi[31]) && (m != 31'd0), m};
    endtask

    task automatic run_op(input logic [31:0] ai, input logic [31:0] bi, input int hold);
        logic [31:0] ep;
        logic        eo;
        int          lat;
        model(ai, bi, ep, eo);
        @(negedge clk);
        a         = ai;
        b         = bi;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        // Keep in_valid high with junk operands: must be ignored outside IDLE.
        a   = $urandom;
        b   = $urandom;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'd31);
        chk("prod", prod, ep);
        chk("ovf", 32'(ovf), 32'(eo));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_prod", prod, ep);
            chk("hold_ovf", 32'(ovf), 32'(eo));
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("out_valid_after_hs", 32'(out_valid), 32'd0);
        chk("in_ready_after_hs", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_prod", prod, 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'h0001_8000, 32'h0002_0000, 0);
        run_op(32'h8001_8000, 32'h0002_0000, 0);
        run_op(32'h8000_8000, 32'h8000_8000, 0);
        run_op(32'h8000_0000, 32'h0001_0000, 0);
        run_op(32'h0000_0001, 32'h0000_0001, 0);
        run_op(32'h0100_0000, 32'h0100_0000, 0);
        run_op(32'h00FF_0000, 32'h0002_0000, 0);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(32'h0000_0000, 32'h8123_4567, 0);
        run_op(32'h0001_8000, 32'h8002_0000, 5);

        // Abort mid-calculation with an asynchronous reset pulse.
        @(negedge clk);
        a        = 32'h0001_8000;
        b        = 32'h0002_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_prod", prod, 32'd0);
        #1;
        rst_n = 1'b1;
        run_op(32'h0001_8000, 32'h0002_0000, 0);

        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 3 != 0) begin
                ra[30:20] = '0;
                rb[30:20] = '0;
            end
            run_op(ra, rb, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
